// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants for the AD polling path
package uart_pkg;
    typedef enum logic [2:0] {IDLE, READ, LOAD, START, DATA, STOP} state_t;
    localparam int         CLK_FREQ_HZ  = 50_000_000;
    localparam int         BAUD_DEFAULT = 115200;
    localparam logic [7:0] CR           = 8'h0D;
    localparam logic [7:0] LF           = 8'h0A;
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: free-running bit-period counter that pulses bit_end on its last count
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic bit_end
);
    localparam int             W    = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk)
        cnt <= (reset || clr || bit_end) ? '0 : cnt + 1'b1;
    assign bit_end = (cnt == LAST);
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a normal-mode FIFO and sends each byte as an 8N1 UART frame,
// pulsing line_done when the stop bit of an EOL byte completes.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] EOL_BYTE     = LF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_en,
    input  logic       empty,
    input  logic [7:0] q,
    output logic       rdreq,
    output logic       tx,
    output logic       busy,
    output logic       line_done
);
    state_t     state, next;
    logic [7:0] sh;
    logic [2:0] idx;
    logic       eol, bit_end, clr;
    // Counter is held at zero until the start bit so every bit gets a full period
    assign clr = state inside {IDLE, READ, LOAD};
    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) baud (
        .clk(clk),
        .reset(reset),
        .clr(clr),
        .bit_end(bit_end)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sh    <= '0;
            idx   <= '0;
            eol   <= 1'b0;
        end else begin
            state <= next;
            if (state == LOAD) begin
                sh  <= q;
                idx <= '0;
                eol <= (q == EOL_BYTE);
            end else if (state == DATA && bit_end) begin
                sh  <= sh >> 1;
                idx <= idx + 3'd1;
            end
        end
    end
    always_comb begin
        next      = state;
        rdreq     = (state == READ);
        busy      = (state != IDLE);
        tx        = (state == START) ? 1'b0 : (state == DATA) ? sh[0] : 1'b1;
        line_done = (state == STOP) && bit_end && eol;
        case (state)
            IDLE:    next = (tx_en && !empty) ? READ : IDLE;
            READ:    next = LOAD;
            LOAD:    next = START;
            START:   next = bit_end ? DATA : START;
            DATA:    next = (bit_end && idx == 3'd7) ? STOP : DATA;
            STOP:    next = bit_end ? IDLE : STOP;
            default: next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed scenarios against a queue-backed normal-mode FIFO model
module tb_fifo_uart_tx;
    localparam int CPB = 4;
    localparam int P   = 10 * CPB + 3;
    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       tx_en = 1'b0;
    logic       empty = 1'b1;
    logic [7:0] q     = 8'h00;
    logic       rdreq, tx, busy, line_done;
    logic [7:0] fifo [$];
    int tests = 0, fails = 0, rd_cnt = 0, rd_bad = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .EOL_BYTE(8'h0A)) dut (
        .clk(clk), .reset(reset), .tx_en(tx_en), .empty(empty), .q(q),
        .rdreq(rdreq), .tx(tx), .busy(busy), .line_done(line_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rdreq && empty) rd_bad <= rd_bad + 1;
        if (rdreq && fifo.size() > 0) begin
            q      <= fifo.pop_front();
            rd_cnt <= rd_cnt + 1;
        end
    end

    always @(negedge clk) begin
        #1;
        empty = (fifo.size() == 0);
    end

    // Expected {tx, rdreq, line_done, busy} at sample k of back-to-back frames
    function automatic logic [3:0] model(input logic [7:0] b [$], input int k);
        int j, o, n;
        logic [7:0] v;
        logic t;
        j = (k - 1) / P;
        o = (k - 1) % P + 1;
        if (j >= b.size() || o == P) return 4'b1000;
        if (o == 1) return 4'b1101;
        if (o == 2) return 4'b1001;
        v = b[j];
        n = (o - 3) / CPB;
        t = (n == 0) ? 1'b0 : (n == 9) ? 1'b1 : v[n-1];
        return {t, 1'b0, (o == P - 1) && (v == 8'h0A), 1'b1};
    endfunction

    task automatic test_reset;
        int bad = 0;
        reset = 1'b1;
        tx_en = 1'b1;
        repeat (3) @(negedge clk);
        tests += 4;
        if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx got %b expected 1", tx); end
        if (rdreq !== 1'b0) begin fails++; $display("FAIL reset_rdreq got %b expected 0", rdreq); end
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b expected 0", busy); end
        if (line_done !== 1'b0) begin fails++; $display("FAIL reset_line_done got %b expected 0", line_done); end
        reset = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || rdreq !== 1'b0 || busy !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL idle_empty got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_single;
        logic [9:0] seq;
        logic e;
        int rd = 0, ld = 0;
        seq = 10'b1101001010;
        @(negedge clk);
        tx_en = 1'b1;
        fifo.push_back(8'hA5);
        for (int k = 1; k <= P; k++) begin
            @(negedge clk);
            e = (k >= 3 && k <= P - 1) ? seq[(k-3)/CPB] : 1'b1;
            tests++;
            if (tx !== e) begin fails++; $display("FAIL single_tx k=%0d got %b expected %b", k, tx, e); end
            if (k == 1) begin
                tests++;
                if (rdreq !== 1'b1) begin fails++; $display("FAIL single_rdreq_n1 got %b expected 1", rdreq); end
            end
            if (rdreq) rd++;
            if (line_done) ld++;
        end
        tests += 3;
        if (rd != 1) begin fails++; $display("FAIL single_rd_count got %0d expected 1", rd); end
        if (ld != 0) begin fails++; $display("FAIL single_line_done got %0d expected 0", ld); end
        if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_end got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] b [$];
        logic [3:0] e, a;
        b.push_back(8'h41);
        b.push_back(8'h0D);
        b.push_back(8'h0A);
        @(negedge clk);
        tx_en = 1'b1;
        foreach (b[i]) fifo.push_back(b[i]);
        for (int k = 1; k <= 3 * P; k++) begin
            @(negedge clk);
            e = model(b, k);
            a = {tx, rdreq, line_done, busy};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL line k=%0d {tx,rdreq,line_done,busy} got %b expected %b", k, a, e);
            end
        end
    endtask

    task automatic test_tx_en;
        logic [9:0] f;
        int rd = 0;
        f = '0;
        @(negedge clk);
        tx_en = 1'b0;
        fifo.push_back(8'h3C);
        repeat (20) begin
            @(negedge clk);
            if (rdreq || busy) rd++;
        end
        tests++;
        if (rd != 0) begin fails++; $display("FAIL txen_hold got %0d active cycles expected 0", rd); end
        tx_en = 1'b1;
        @(negedge clk);
        tests++;
        if (rdreq !== 1'b1) begin fails++; $display("FAIL txen_rdreq got %b expected 1", rdreq); end
        for (int m = 2; m <= P; m++) begin
            @(negedge clk);
            if (m == 10) tx_en = 1'b0;
            if (m >= 3 && (m - 3) % CPB == 1) f[(m-3)/CPB] = tx;
            if (m == P - 1) begin
                tests++;
                if (busy !== 1'b1) begin fails++; $display("FAIL txen_busy_stop got %b expected 1", busy); end
            end
        end
        tests += 2;
        if (f !== {1'b1, 8'h3C, 1'b0}) begin fails++; $display("FAIL txen_frame got %b expected %b", f, {1'b1, 8'h3C, 1'b0}); end
        if (busy !== 1'b0) begin fails++; $display("FAIL txen_busy_end got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid;
        logic [9:0] f;
        f = '0;
        @(negedge clk);
        tx_en = 1'b1;
        fifo.push_back(8'h00);
        fifo.push_back(8'hC3);
        repeat (20) @(negedge clk);
        tests++;
        if (tx !== 1'b0) begin fails++; $display("FAIL mid_bit3 got %b expected 0", tx); end
        reset = 1'b1;
        @(negedge clk);
        tests += 3;
        if (tx !== 1'b1) begin fails++; $display("FAIL mid_reset_tx got %b expected 1", tx); end
        if (busy !== 1'b0) begin fails++; $display("FAIL mid_reset_busy got %b expected 0", busy); end
        if (rdreq !== 1'b0) begin fails++; $display("FAIL mid_reset_rdreq got %b expected 0", rdreq); end
        reset = 1'b0;
        for (int n = 1; n <= P; n++) begin
            @(negedge clk);
            if (n == 1) begin
                tests++;
                if (rdreq !== 1'b1) begin fails++; $display("FAIL mid_next_rdreq got %b expected 1", rdreq); end
            end
            if (n >= 3 && (n - 3) % CPB == 1) f[(n-3)/CPB] = tx;
        end
        tests++;
        if (f !== {1'b1, 8'hC3, 1'b0}) begin fails++; $display("FAIL mid_next_frame got %b expected %b", f, {1'b1, 8'hC3, 1'b0}); end
    endtask

    task automatic test_random;
        logic [7:0] exp [$];
        logic [7:0] v;
        logic stop;
        int base, to;
        @(negedge clk);
        tx_en = 1'b1;
        base = rd_cnt;
        for (int i = 0; i < 64; i++) begin
            v = 8'($urandom_range(0, 255));
            exp.push_back(v);
            fifo.push_back(v);
        end
        for (int i = 0; i < 64; i++) begin
            to = 0;
            while (tx !== 1'b0 && to < 200) begin
                @(negedge clk);
                to++;
            end
            if (to >= 200) begin
                tests++;
                fails++;
                $display("FAIL rand_timeout byte=%0d got no start bit expected one within 200 cycles", i);
                break;
            end
            repeat (CPB + 1) @(negedge clk);
            v[0] = tx;
            for (int b = 1; b < 8; b++) begin
                repeat (CPB) @(negedge clk);
                v[b] = tx;
            end
            repeat (CPB) @(negedge clk);
            stop = tx;
            tests++;
            if ({stop, v} !== {1'b1, exp[i]}) begin
                fails++;
                $display("FAIL rand_byte %0d got stop=%b data=%h expected stop=1 data=%h", i, stop, v, exp[i]);
            end
        end
        repeat (10) @(negedge clk);
        tests += 3;
        if (rd_cnt - base != 64) begin fails++; $display("FAIL rand_rd_count got %0d expected 64", rd_cnt - base); end
        if (rd_bad != 0) begin fails++; $display("FAIL rand_rd_on_empty got %0d expected 0", rd_bad); end
        if (busy !== 1'b0) begin fails++; $display("FAIL rand_busy_end got %b expected 0", busy); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_tx_en;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
